// File: rtl/usr_types_and_params.sv
// Shared constants and types for the Avalon-ST arbitrating multiplexer.
package usr_types_and_params;

    localparam int DATA_WIDTH    = 64;
    localparam int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8);
    localparam int CHANNEL_WIDTH = 10;
    localparam int RX_DIR        = 4;
    localparam int SRC_SEL_WIDTH = $clog2(RX_DIR);

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

endpackage

// File: rtl/ast_rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant wins.
module ast_rr_arbiter #(
    parameter int RX_DIR        = usr_types_and_params::RX_DIR,
    parameter int SRC_SEL_WIDTH = $clog2(RX_DIR)
) (
    input  logic [RX_DIR-1:0]        req_i,
    input  logic [SRC_SEL_WIDTH-1:0] last_grant_i,
    output logic [SRC_SEL_WIDTH-1:0] winner_o,
    output logic                     any_req_o
);

    // cand[i] is the input sitting i+1 places after last_grant in the ring
    logic [RX_DIR-1:0][SRC_SEL_WIDTH-1:0] cand;
    logic [RX_DIR-1:0]                    hit;

    generate
        for (genvar gi = 0; gi < RX_DIR; gi++) begin : g_rot
            assign cand[gi] = SRC_SEL_WIDTH'((int'(last_grant_i) + gi + 1) % RX_DIR);
            assign hit[gi]  = req_i[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner_o = '0;
        for (int i = RX_DIR - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner_o = cand[i];
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/ast_arb_mux.sv
// Avalon-ST N:1 packet multiplexer; round-robin grant held from SOP to EOP,
// registered output tagged with the source index.
module ast_arb_mux #(
    parameter int DATA_WIDTH    = 64,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int CHANNEL_WIDTH = 10,
    parameter int RX_DIR        = 4,
    parameter int SRC_SEL_WIDTH = $clog2(RX_DIR)
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [DATA_WIDTH-1:0]    ast_data_i          [RX_DIR],
    input  logic [RX_DIR-1:0]        ast_startofpacket_i,
    input  logic [RX_DIR-1:0]        ast_endofpacket_i,
    input  logic [RX_DIR-1:0]        ast_valid_i,
    input  logic [EMPTY_WIDTH-1:0]   ast_empty_i         [RX_DIR],
    input  logic [CHANNEL_WIDTH-1:0] ast_channel_i       [RX_DIR],
    output logic [RX_DIR-1:0]        ast_ready_o,
    output logic [DATA_WIDTH-1:0]    ast_data_o,
    output logic                     ast_startofpacket_o,
    output logic                     ast_endofpacket_o,
    output logic                     ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
    output logic [SRC_SEL_WIDTH-1:0] ast_src_o,
    input  logic                     ast_ready_i
);

    usr_types_and_params::arb_state_t state_q, state_d;

    logic [SRC_SEL_WIDTH-1:0] grant_q, grant_d;
    logic [SRC_SEL_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     sop_q, sop_d;
    logic                     eop_q, eop_d;
    logic                     valid_q, valid_d;
    logic [EMPTY_WIDTH-1:0]   empty_q, empty_d;
    logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;
    logic [SRC_SEL_WIDTH-1:0] src_q, src_d;

    logic [RX_DIR-1:0]        req;
    logic [SRC_SEL_WIDTH-1:0] winner;
    logic                     any_req;
    logic                     out_free;
    logic                     accept;

    assign req      = ast_valid_i & ast_startofpacket_i;
    assign out_free = !valid_q || ast_ready_i;

    ast_rr_arbiter #(
        .RX_DIR        (RX_DIR),
        .SRC_SEL_WIDTH (SRC_SEL_WIDTH)
    ) u_arb (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_req_o    (any_req)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        valid_d      = valid_q;
        empty_d      = empty_q;
        channel_d    = channel_q;
        src_d        = src_q;
        ast_ready_o  = '0;
        accept       = 1'b0;

        if (state_q == usr_types_and_params::IDLE) begin
            if (any_req) begin
                grant_d = winner;
                state_d = usr_types_and_params::BUSY;
            end
        end else begin
            ast_ready_o[grant_q] = out_free;
            accept               = ast_valid_i[grant_q] && out_free;
            if (accept && ast_endofpacket_i[grant_q]) begin
                state_d      = usr_types_and_params::IDLE;
                last_grant_d = grant_q;
            end
        end

        // The register also drains in IDLE so a consumed last beat is not repeated.
        if (accept) begin
            data_d    = ast_data_i[grant_q];
            sop_d     = ast_startofpacket_i[grant_q];
            eop_d     = ast_endofpacket_i[grant_q];
            empty_d   = ast_empty_i[grant_q];
            channel_d = ast_channel_i[grant_q];
            src_d     = grant_q;
            valid_d   = 1'b1;
        end else if (out_free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= usr_types_and_params::IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_SEL_WIDTH'(RX_DIR - 1);
            data_q       <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            valid_q      <= 1'b0;
            empty_q      <= '0;
            channel_q    <= '0;
            src_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            valid_q      <= valid_d;
            empty_q      <= empty_d;
            channel_q    <= channel_d;
            src_q        <= src_d;
        end
    end

    assign ast_data_o          = data_q;
    assign ast_startofpacket_o = sop_q;
    assign ast_endofpacket_o   = eop_q;
    assign ast_valid_o         = valid_q;
    assign ast_empty_o         = empty_q;
    assign ast_channel_o       = channel_q;
    assign ast_src_o           = src_q;

endmodule
